fb_write_scheduler: RTL and testbench

//  Sequences all writes into the framebuffer region of DRAM. Sits between the fragment

---
 rtl/fb_write_scheduler.sv | 238 +++++++++++++++++++++++
 tb/tb_fb_write_scheduler.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_write_scheduler.sv
// ---------------------------------------------------------------------------
// fb_write_scheduler
//
// Sequences every write into the framebuffer region of DRAM. Pixel writes
// from the fragment stream are buffered in a small FIFO (the linear pixel
// index is computed on enqueue). A host clear command runs a full-screen
// clear engine. Pixels accepted before or in the same cycle as the clear
// command are written before clear address 0. Pixels arriving later are
// held off (o_pixel_ready=0) until the clear-done pulse.
//
// Optional feature (macro FB_SCHED_DROP_CNT_EN):
//   When defined, adds o_drop_count[15:0]. It is a saturating count of
//   out-of-range pixels that were consumed but not written. When undefined,
//   the port and the counter do not exist.
//
// Ports
//   clk            in   rising-edge clock
//   rst_n          in   asynchronous active-low reset
//   i_pixel_we     in   pixel valid
//   i_pixel_x/y    in   pixel column / row (10 bits each)
//   i_pixel_color  in   pixel colour
//   o_pixel_ready  out  pixel handshake (accept = i_pixel_we && o_pixel_ready)
//   i_clear_start  in   1-cycle clear command (ignored while busy)
//   i_clear_color  in   clear colour, sampled with an accepted i_clear_start
//   o_clear_busy   out  clear pending or in progress
//   o_clear_done   out  1-cycle pulse after the last clear write is acked
//   o_drop_count   out  saturating drop count (FB_SCHED_DROP_CNT_EN only)
//   o_mem_req      out  registered write request
//   o_mem_addr     out  pixel index y*SCREEN_WIDTH + x
//   o_mem_wdata    out  write data
//   i_mem_ack      in   transfer completes when o_mem_req && i_mem_ack
// ---------------------------------------------------------------------------
module fb_write_scheduler #(
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int COLOR_WIDTH   = 32,
    parameter int FIFO_DEPTH    = 8,
    localparam int PIX_AW       = $clog2(SCREEN_WIDTH * SCREEN_HEIGHT)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_pixel_we,
    input  logic [9:0]             i_pixel_x,
    input  logic [9:0]             i_pixel_y,
    input  logic [COLOR_WIDTH-1:0] i_pixel_color,
    output logic                   o_pixel_ready,
    input  logic                   i_clear_start,
    input  logic [COLOR_WIDTH-1:0] i_clear_color,
    output logic                   o_clear_busy,
    output logic                   o_clear_done,
`ifdef FB_SCHED_DROP_CNT_EN
    output logic [15:0]            o_drop_count,
`endif
    output logic                   o_mem_req,
    output logic [PIX_AW-1:0]      o_mem_addr,
    output logic [COLOR_WIDTH-1:0] o_mem_wdata,
    input  logic                   i_mem_ack
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int NPIX  = SCREEN_WIDTH * SCREEN_HEIGHT;
    localparam logic [PIX_AW-1:0] LAST_ADDR = PIX_AW'(NPIX - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PIX  = 2'd1;
    localparam logic [1:0] ST_CLR  = 2'd2;

    typedef struct packed {
        logic [PIX_AW-1:0]      addr;
        logic [COLOR_WIDTH-1:0] color;
    } fifo_entry_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]             state;
    logic                   clear_pending;
    logic [COLOR_WIDTH-1:0] clear_color;

    fifo_entry_t            fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0]         wr_ptr;
    logic [PTR_W:0]         rd_ptr;
    logic [PTR_W:0]         fifo_count;
    logic                   fifo_empty;
    logic                   fifo_full;

    // ------------------------------------------------------------------
    // Accept path
    // ------------------------------------------------------------------
    logic [31:0]            x_ext;
    logic [31:0]            y_ext;
    logic                   pixel_in_range;
    logic                   accept;
    logic                   push;
    logic                   pop;
    fifo_entry_t            push_entry;
    fifo_entry_t            head_entry;
    fifo_entry_t            next_entry;
    logic [PTR_W-1:0]       rd_idx_next;

    assign fifo_count = wr_ptr - rd_ptr;
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (fifo_count == (PTR_W+1)'(FIFO_DEPTH));

    assign o_clear_busy  = clear_pending || (state == ST_CLR);
    assign o_pixel_ready = !fifo_full && !o_clear_busy;

    assign x_ext          = 32'(i_pixel_x);
    assign y_ext          = 32'(i_pixel_y);
    assign pixel_in_range = (x_ext < 32'(SCREEN_WIDTH)) && (y_ext < 32'(SCREEN_HEIGHT));

    // Out-of-range pixels still complete the handshake; they are just not queued.
    assign accept = i_pixel_we && o_pixel_ready;
    assign push   = accept && pixel_in_range;

    assign push_entry.addr  = PIX_AW'(y_ext * 32'(SCREEN_WIDTH) + x_ext);
    assign push_entry.color = i_pixel_color;

    // The head stays in the FIFO while it is being written; it is popped on ack.
    assign pop = (state == ST_PIX) && o_mem_req && i_mem_ack;

    assign rd_idx_next = rd_ptr[PTR_W-1:0] + PTR_W'(1);
    assign head_entry  = fifo_mem[rd_ptr[PTR_W-1:0]];
    // Entry to present right after popping the head: the one behind it, or the
    // pixel being pushed this very cycle when the head was the only entry.
    assign next_entry  = (fifo_count > (PTR_W+1)'(1)) ? fifo_mem[rd_idx_next] : push_entry;

    // ------------------------------------------------------------------
    // FIFO storage and pointers
    // ------------------------------------------------------------------
    // NOTE: the storage array has no reset; pointers alone define validity,
    // so a reset discards contents without clearing every word.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[PTR_W-1:0]] <= push_entry;
        end
    end

    // NOTE: sequential state is always updated with non-blocking assignments,
    // so every block sees the pre-edge values regardless of evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
        end
    end

    // ------------------------------------------------------------------
    // Write sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            clear_pending <= 1'b0;
            clear_color   <= '0;
            o_mem_req     <= 1'b0;
            o_mem_addr    <= '0;
            o_mem_wdata   <= '0;
            o_clear_done  <= 1'b0;
        end else begin
            o_clear_done <= 1'b0;

            // A start while busy is ignored and does not re-sample the colour.
            if (i_clear_start && !o_clear_busy) begin
                clear_pending <= 1'b1;
                clear_color   <= i_clear_color;
            end

            case (state)
                ST_IDLE: begin
                    // Queued pixels always drain before the clear begins.
                    if (clear_pending && fifo_empty) begin
                        state         <= ST_CLR;
                        clear_pending <= 1'b0;
                        o_mem_req     <= 1'b1;
                        o_mem_addr    <= '0;
                        o_mem_wdata   <= clear_color;
                    end else if (!fifo_empty) begin
                        state       <= ST_PIX;
                        o_mem_req   <= 1'b1;
                        o_mem_addr  <= head_entry.addr;
                        o_mem_wdata <= head_entry.color;
                    end
                end

                ST_PIX: begin
                    if (i_mem_ack) begin
                        if ((fifo_count > (PTR_W+1)'(1)) || push) begin
                            o_mem_addr  <= next_entry.addr;
                            o_mem_wdata <= next_entry.color;
                        end else begin
                            state     <= ST_IDLE;
                            o_mem_req <= 1'b0;
                        end
                    end
                end

                ST_CLR: begin
                    if (i_mem_ack) begin
                        if (o_mem_addr == LAST_ADDR) begin
                            state        <= ST_IDLE;
                            o_mem_req    <= 1'b0;
                            o_clear_done <= 1'b1;
                        end else begin
                            o_mem_addr <= o_mem_addr + PIX_AW'(1);
                        end
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    o_mem_req <= 1'b0;
                end
            endcase
        end
    end

`ifdef FB_SCHED_DROP_CNT_EN
    // ------------------------------------------------------------------
    // Saturating count of consumed out-of-range pixels
    // ------------------------------------------------------------------
    logic drop;

    assign drop = accept && !pixel_in_range;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_drop_count <= '0;
        end else if (drop && (o_drop_count != 16'hFFFF)) begin
            o_drop_count <= o_drop_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fb_write_scheduler.sv
// ---------------------------------------------------------------------------
// tb_fb_write_scheduler
//
// Two instances share one clock:
//   dut_a : default 640x480 geometry (pixel path, FIFO back-pressure, drops)
//   dut_b : 4x2 geometry (clear engine, ordering, reset during clear)
// Expected writes are pushed to a per-instance scoreboard queue when the
// stimulus is driven and compared in order whenever a write handshakes.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
// ---------------------------------------------------------------------------
module tb_fb_write_scheduler;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    int checks = 0;
    int errors = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- instance A (640x480) ----------------
    logic        a_rst_n, a_we, a_ready, a_cs, a_busy, a_done, a_req, a_ack;
    logic [9:0]  a_x, a_y;
    logic [31:0] a_color, a_cc, a_wdata;
    logic [18:0] a_addr;
`ifdef FB_SCHED_DROP_CNT_EN
    logic [15:0] a_drop;
`endif

    // ---------------- instance B (4x2) ----------------
    logic        b_rst_n, b_we, b_ready, b_cs, b_busy, b_done, b_req, b_ack;
    logic [9:0]  b_x, b_y;
    logic [31:0] b_color, b_cc, b_wdata;
    logic [2:0]  b_addr;
`ifdef FB_SCHED_DROP_CNT_EN
    logic [15:0] b_drop;
`endif

    fb_write_scheduler dut_a (
        .clk           (clk),
        .rst_n         (a_rst_n),
        .i_pixel_we    (a_we),
        .i_pixel_x     (a_x),
        .i_pixel_y     (a_y),
        .i_pixel_color (a_color),
        .o_pixel_ready (a_ready),
        .i_clear_start (a_cs),
        .i_clear_color (a_cc),
        .o_clear_busy  (a_busy),
        .o_clear_done  (a_done),
`ifdef FB_SCHED_DROP_CNT_EN
        .o_drop_count  (a_drop),
`endif
        .o_mem_req     (a_req),
        .o_mem_addr    (a_addr),
        .o_mem_wdata   (a_wdata),
        .i_mem_ack     (a_ack)
    );

    fb_write_scheduler #(
        .SCREEN_WIDTH  (4),
        .SCREEN_HEIGHT (2),
        .COLOR_WIDTH   (32),
        .FIFO_DEPTH    (8)
    ) dut_b (
        .clk           (clk),
        .rst_n         (b_rst_n),
        .i_pixel_we    (b_we),
        .i_pixel_x     (b_x),
        .i_pixel_y     (b_y),
        .i_pixel_color (b_color),
        .o_pixel_ready (b_ready),
        .i_clear_start (b_cs),
        .i_clear_color (b_cc),
        .o_clear_busy  (b_busy),
        .o_clear_done  (b_done),
`ifdef FB_SCHED_DROP_CNT_EN
        .o_drop_count  (b_drop),
`endif
        .o_mem_req     (b_req),
        .o_mem_addr    (b_addr),
        .o_mem_wdata   (b_wdata),
        .i_mem_ack     (b_ack)
    );

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea;
    exp_t eb;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- scoreboard monitors ----------------
    always @(negedge clk) begin
        if (a_rst_n && a_req && a_ack) begin
            checks++;
            assert (qa.size() > 0) else begin
                errors++;
                $error("FAIL a_spurious_write: addr %0d data %h with nothing expected", a_addr, a_wdata);
            end
            if (qa.size() > 0) begin
                ea = qa.pop_front();
                check("a_write_addr", 64'(a_addr), 64'(ea.addr));
                check("a_write_data", 64'(a_wdata), 64'(ea.data));
            end
        end
    end

    always @(negedge clk) begin
        if (b_rst_n && b_req && b_ack) begin
            checks++;
            assert (qb.size() > 0) else begin
                errors++;
                $error("FAIL b_spurious_write: addr %0d data %h with nothing expected", b_addr, b_wdata);
            end
            if (qb.size() > 0) begin
                eb = qb.pop_front();
                check("b_write_addr", 64'(b_addr), 64'(eb.addr));
                check("b_write_data", 64'(b_wdata), 64'(eb.data));
            end
        end
    end

    // Safety net: the directed sequence is bounded, this only guards a hang.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach the end, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin
        bit accepted;
        bit done_seen;

        a_rst_n = 1'b0; a_we = 1'b0; a_x = '0; a_y = '0; a_color = '0;
        a_cs = 1'b0; a_cc = '0; a_ack = 1'b1;
        b_rst_n = 1'b0; b_we = 1'b0; b_x = '0; b_y = '0; b_color = '0;
        b_cs = 1'b0; b_cc = '0; b_ack = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;

        // ---- reset state (first cycle after release) ----
        @(negedge clk);
        check("rst_req",   64'(a_req),   64'(0));
        check("rst_addr",  64'(a_addr),  64'(0));
        check("rst_wdata", 64'(a_wdata), 64'(0));
        check("rst_busy",  64'(a_busy),  64'(0));
        check("rst_done",  64'(a_done),  64'(0));
        check("rst_ready", 64'(a_ready), 64'(1));
`ifdef FB_SCHED_DROP_CNT_EN
        check("rst_drop",  64'(a_drop),  64'(0));
`endif

        // ---- 1: single pixel, ack tied high, request exactly at N+2 ----
        step();
        a_we = 1'b1; a_x = 10'd3; a_y = 10'd2; a_color = 32'hDEADBEEF;
        qa.push_back('{addr: 32'd1283, data: 32'hDEADBEEF});
        @(negedge clk);
        check("t1_accept_ready", 64'(a_ready), 64'(1));
        step();
        a_we = 1'b0;
        @(negedge clk);
        check("t1_req_n1", 64'(a_req), 64'(0));
        step();
        @(negedge clk);
        check("t1_req_n2", 64'(a_req), 64'(1));
        step();
        @(negedge clk);
        check("t1_req_n3", 64'(a_req), 64'(0));

        // ---- 2: ack held low, 9 pushes, only 8 accepted, then drain ----
        a_ack = 1'b0;
        for (int i = 0; i < 9; i++) begin
            step();
            a_we = 1'b1; a_x = 10'(10 + i); a_y = 10'd5; a_color = 32'hC0DE0000 + 32'(i);
            @(negedge clk);
            check("t2_ready", 64'(a_ready), 64'(i < 8));
            if (a_ready) qa.push_back('{addr: 32'(5 * 640 + 10 + i), data: 32'hC0DE0000 + 32'(i)});
        end
        step();
        a_we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t2_stall_req",   64'(a_req),   64'(1));
            check("t2_stall_addr",  64'(a_addr),  64'(3210));
            check("t2_stall_wdata", 64'(a_wdata), 64'(32'hC0DE0000));
            check("t2_stall_ready", 64'(a_ready), 64'(0));
            step();
        end
        a_ack = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("t2_drain_no_bubble", 64'(a_req), 64'(1));
            step();
        end
        @(negedge clk);
        check("t2_drain_end_req", 64'(a_req), 64'(0));
        check("t2_queue_empty", 64'(qa.size()), 64'(0));

        // ---- 5: out-of-range pixel consumed, nothing written ----
        step();
        a_we = 1'b1; a_x = 10'd640; a_y = 10'd0; a_color = 32'h0BADC0DE;
        @(negedge clk);
        check("t5_drop_ready", 64'(a_ready), 64'(1));
        step();
        a_we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t5_no_req", 64'(a_req), 64'(0));
            step();
        end
`ifdef FB_SCHED_DROP_CNT_EN
        @(negedge clk);
        check("t5_drop_count_1", 64'(a_drop), 64'(1));
        step();
        a_we = 1'b1; a_x = 10'd700; a_y = 10'd1;
        for (int k = 0; k < 65536; k++) step();
        a_we = 1'b0;
        step();
        @(negedge clk);
        check("t5_drop_saturated", 64'(a_drop), 64'(16'hFFFF));
        check("t5_sat_no_req", 64'(a_req), 64'(0));
        step();
`endif

        // ---- 3: 4x2 clear, ack high ----
        step();
        b_ack = 1'b1; b_cs = 1'b1; b_cc = 32'h00FF00FF;
        for (int k = 0; k < 8; k++) qb.push_back('{addr: 32'(k), data: 32'h00FF00FF});
        @(negedge clk);
        check("t3_busy_start_cycle", 64'(b_busy), 64'(0));
        step();
        b_cs = 1'b0;
        @(negedge clk);
        check("t3_busy_rise", 64'(b_busy),  64'(1));
        check("t3_ready_blk", 64'(b_ready), 64'(0));
        for (int k = 0; k < 8; k++) begin
            step();
            @(negedge clk);
            check("t3_clr_req",  64'(b_req),  64'(1));
            check("t3_clr_busy", 64'(b_busy), 64'(1));
            check("t3_clr_done", 64'(b_done), 64'(0));
        end
        step();
        @(negedge clk);
        check("t3_done_pulse", 64'(b_done),  64'(1));
        check("t3_done_busy",  64'(b_busy),  64'(0));
        check("t3_done_req",   64'(b_req),   64'(0));
        check("t3_done_ready", 64'(b_ready), 64'(1));
        step();
        @(negedge clk);
        check("t3_done_single", 64'(b_done), 64'(0));
        check("t3_queue_empty", 64'(qb.size()), 64'(0));

        // ---- 4: queued pixels, clear start (with a same-cycle pixel), late pixel ----
        b_ack = 1'b0;
        step();
        b_we = 1'b1; b_x = 10'd1; b_y = 10'd0; b_color = 32'hA1A1A1A1;
        qb.push_back('{addr: 32'd1, data: 32'hA1A1A1A1});
        @(negedge clk);
        check("t4_ready_p1", 64'(b_ready), 64'(1));
        step();
        b_x = 10'd2; b_y = 10'd1; b_color = 32'hA2A2A2A2;
        qb.push_back('{addr: 32'd6, data: 32'hA2A2A2A2});
        @(negedge clk);
        check("t4_ready_p2", 64'(b_ready), 64'(1));
        step();
        b_x = 10'd3; b_y = 10'd1; b_color = 32'hA3A3A3A3;
        b_cs = 1'b1; b_cc = 32'h55555555;
        qb.push_back('{addr: 32'd7, data: 32'hA3A3A3A3});
        for (int k = 0; k < 8; k++) qb.push_back('{addr: 32'(k), data: 32'h55555555});
        @(negedge clk);
        check("t4_ready_same_cycle", 64'(b_ready), 64'(1));
        step();
        b_cs = 1'b0; b_x = 10'd0; b_y = 10'd1; b_color = 32'hA4A4A4A4;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t4_ready_blocked_stall", 64'(b_ready), 64'(0));
            check("t4_busy_stall",          64'(b_busy),  64'(1));
            step();
        end
        b_ack = 1'b1;
        accepted  = 1'b0;
        done_seen = 1'b0;
        for (int k = 0; k < 40 && !accepted; k++) begin
            @(negedge clk);
            if (b_done) done_seen = 1'b1;
            check("t4_ready_until_done", 64'(b_ready), 64'(done_seen));
            if (b_ready) begin
                qb.push_back('{addr: 32'd4, data: 32'hA4A4A4A4});
                accepted = 1'b1;
            end
            step();
        end
        b_we = 1'b0;
        check("t4_late_pixel_accepted", 64'(accepted), 64'(1));
        repeat (4) step();
        @(negedge clk);
        check("t4_queue_empty", 64'(qb.size()), 64'(0));
        check("t4_idle_req",    64'(b_req),     64'(0));

        // ---- 6: reset during clear at address 3, then a clean clear ----
        step();
        b_ack = 1'b1; b_cs = 1'b1; b_cc = 32'h0BADF00D;
        for (int k = 0; k < 4; k++) qb.push_back('{addr: 32'(k), data: 32'h0BADF00D});
        step();
        b_cs = 1'b0;
        repeat (4) step();
        @(negedge clk);
        check("t6_at_addr3", 64'(b_addr), 64'(3));
        check("t6_req_addr3", 64'(b_req), 64'(1));
        #2;
        b_rst_n = 1'b0;
        #1;
        check("t6_rst_req",   64'(b_req),   64'(0));
        check("t6_rst_addr",  64'(b_addr),  64'(0));
        check("t6_rst_wdata", 64'(b_wdata), 64'(0));
        check("t6_rst_busy",  64'(b_busy),  64'(0));
        check("t6_rst_done",  64'(b_done),  64'(0));
        step();
        @(negedge clk);
        check("t6_rst_no_done", 64'(b_done), 64'(0));
        step();
        b_rst_n = 1'b1;
        @(negedge clk);
        check("t6_after_rst_busy", 64'(b_busy), 64'(0));
        check("t6_after_rst_done", 64'(b_done), 64'(0));
        check("t6_queue_empty", 64'(qb.size()), 64'(0));
        step();
        b_cs = 1'b1; b_cc = 32'h12345678;
        for (int k = 0; k < 8; k++) qb.push_back('{addr: 32'(k), data: 32'h12345678});
        step();
        b_cs = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            @(negedge clk);
            check("t6_reclr_req",  64'(b_req),  64'(1));
            check("t6_reclr_done", 64'(b_done), 64'(0));
        end
        step();
        @(negedge clk);
        check("t6_reclr_done_pulse", 64'(b_done), 64'(1));
        check("t6_reclr_busy",       64'(b_busy), 64'(0));
        step();

        check("final_qa_empty", 64'(qa.size()), 64'(0));
        check("final_qb_empty", 64'(qb.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
